// File: rtl/pixel_timing_gen_if.sv
// Raster timing bundle driven by pixel_timing_gen (master) and sampled by the
// video datapath (slave) in the cycle pixel_clk is high.
interface pixel_timing_gen_if;
    logic        pixel_clk;
    logic        hsync;
    logic        vsync;
    logic        active;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [19:0] pixel_addr;
    logic        frame_flag;

    modport master (
        output pixel_clk,
        output hsync,
        output vsync,
        output active,
        output hcount,
        output vcount,
        output pixel_addr,
        output frame_flag
    );

    modport slave (
        input pixel_clk,
        input hsync,
        input vsync,
        input active,
        input hcount,
        input vcount,
        input pixel_addr,
        input frame_flag
    );
endinterface

// File: rtl/pixel_timing_gen.sv
// Pixel-rate strobe divider plus horizontal/vertical raster counters with
// sync, active-video, linear address and end-of-frame outputs.
module pixel_timing_gen #(
    parameter int CLK_DIV  = 6,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      s_rst,
    input  logic                      enable,
    pixel_timing_gen_if.master        vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO   = DIV_W'(0);
    localparam logic [9:0]       H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]       V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]       H_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]       V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0]       HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]       HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]       VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]       VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt_r;
    logic             pixel_clk_r;
    logic             hsync_r;
    logic             vsync_r;
    logic             active_r;
    logic [9:0]       hcount_r;
    logic [9:0]       vcount_r;
    logic [19:0]      pixel_addr_r;
    logic             frame_flag_r;

    logic             tick_s;
    logic [9:0]       h_next_s;
    logic [9:0]       v_next_s;
    logic             active_next_s;
    logic             hsync_next_s;
    logic             vsync_next_s;
    logic             frame_next_s;
    logic [19:0]      addr_next_s;

    // Strobe qualifier: last divider count while running.
    always_comb begin
        tick_s = enable && (div_cnt_r == DIV_LAST);
    end

    // Next raster position; vcount only moves when hcount wraps.
    always_comb begin
        h_next_s = hcount_r;
        v_next_s = vcount_r;
        if (hcount_r == H_LAST) begin
            h_next_s = 10'd0;
            if (vcount_r == V_LAST) begin
                v_next_s = 10'd0;
            end else begin
                v_next_s = vcount_r + 10'd1;
            end
        end else begin
            h_next_s = hcount_r + 10'd1;
            v_next_s = vcount_r;
        end
    end

    // Derived outputs evaluated on the new position so they land with the strobe.
    always_comb begin
        active_next_s = (h_next_s < H_ACT) && (v_next_s < V_ACT);
        hsync_next_s  = !((h_next_s >= HS_FIRST) && (h_next_s <= HS_LAST));
        vsync_next_s  = !((v_next_s >= VS_FIRST) && (v_next_s <= VS_LAST));
        frame_next_s  = (h_next_s == H_ACT_LAST) && (v_next_s == V_ACT_LAST);
        addr_next_s   = pixel_addr_r;
        if ((h_next_s == 10'd0) && (v_next_s == 10'd0)) begin
            addr_next_s = 20'd0;
        end else if (active_next_s) begin
            addr_next_s = pixel_addr_r + 20'd1;
        end else begin
            addr_next_s = pixel_addr_r;
        end
    end

    // Divider and raster state; reset parks at the last position so the first tick lands on (0,0).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_cnt_r    <= DIV_ZERO;
            pixel_clk_r  <= 1'b0;
            hsync_r      <= 1'b1;
            vsync_r      <= 1'b1;
            active_r     <= 1'b0;
            hcount_r     <= H_LAST;
            vcount_r     <= V_LAST;
            pixel_addr_r <= 20'd0;
            frame_flag_r <= 1'b0;
        end else if (s_rst) begin
            div_cnt_r    <= DIV_ZERO;
            pixel_clk_r  <= 1'b0;
            hsync_r      <= 1'b1;
            vsync_r      <= 1'b1;
            active_r     <= 1'b0;
            hcount_r     <= H_LAST;
            vcount_r     <= V_LAST;
            pixel_addr_r <= 20'd0;
            frame_flag_r <= 1'b0;
        end else if (tick_s) begin
            div_cnt_r    <= DIV_ZERO;
            pixel_clk_r  <= 1'b1;
            hsync_r      <= hsync_next_s;
            vsync_r      <= vsync_next_s;
            active_r     <= active_next_s;
            hcount_r     <= h_next_s;
            vcount_r     <= v_next_s;
            pixel_addr_r <= addr_next_s;
            frame_flag_r <= frame_next_s;
        end else begin
            pixel_clk_r  <= 1'b0;
            frame_flag_r <= 1'b0;
            if (enable) begin
                div_cnt_r <= div_cnt_r + DIV_ONE;
            end else begin
                div_cnt_r <= div_cnt_r;
            end
        end
    end

    assign vid.pixel_clk  = pixel_clk_r;
    assign vid.hsync      = hsync_r;
    assign vid.vsync      = vsync_r;
    assign vid.active     = active_r;
    assign vid.hcount     = hcount_r;
    assign vid.vcount     = vcount_r;
    assign vid.pixel_addr = pixel_addr_r;
    assign vid.frame_flag = frame_flag_r;

endmodule

// File: tb/tb_pixel_timing_gen.sv
// Directed bench: full-size raster for strobe/line/pause/reset behaviour, and a
// shrunken raster (16x12, CLK_DIV=2) to cover a whole frame in few cycles.
module tb_pixel_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst;
    logic s_rst;
    logic en_a;
    logic en_b;
    logic use_b;

    pixel_timing_gen_if vid_a();
    pixel_timing_gen_if vid_b();

    pixel_timing_gen u_dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .s_rst  (s_rst),
        .enable (en_a),
        .vid    (vid_a)
    );

    pixel_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .clk    (clk),
        .n_rst  (n_rst),
        .s_rst  (s_rst),
        .enable (en_b),
        .vid    (vid_b)
    );

    logic        c_pclk, c_hs, c_vs, c_act, c_ff;
    logic [9:0]  c_h, c_v;
    logic [19:0] c_addr;
    assign c_pclk = use_b ? vid_b.pixel_clk  : vid_a.pixel_clk;
    assign c_hs   = use_b ? vid_b.hsync      : vid_a.hsync;
    assign c_vs   = use_b ? vid_b.vsync      : vid_a.vsync;
    assign c_act  = use_b ? vid_b.active     : vid_a.active;
    assign c_ff   = use_b ? vid_b.frame_flag : vid_a.frame_flag;
    assign c_h    = use_b ? vid_b.hcount     : vid_a.hcount;
    assign c_v    = use_b ? vid_b.vcount     : vid_a.vcount;
    assign c_addr = use_b ? vid_b.pixel_addr : vid_a.pixel_addr;

    int checks = 0;
    int errors = 0;
    int gap;
    int bad_gap = 0;
    int ff_cycles = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next strobe, recording the gap in clocks.
    task automatic step(input int limit, input int exp_gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
            if (c_ff === 1'b1) ff_cycles++;
        end while (c_pclk !== 1'b1 && gap < limit);
        if (c_pclk !== 1'b1) check("strobe_timeout", {31'd0, c_pclk}, 32'd1);
        if (gap != exp_gap) bad_gap++;
    endtask

    initial begin
        int hold_bad;
        int vs_bad, hs_bad, act_bad, addr_bad, vs_low, frame_seen, clk_cnt;
        logic exp_vs, exp_hs, exp_act;

        n_rst = 1'b1; s_rst = 1'b0; en_a = 1'b0; en_b = 1'b0; use_b = 1'b0;

        // Asynchronous reset mid-cycle, checked before any clock edge
        #3 n_rst = 1'b0;
        #1;
        check("rst_hcount", c_h, 799);
        check("rst_vcount", c_v, 524);
        check("rst_hsync", c_hs, 1);
        check("rst_vsync", c_vs, 1);
        check("rst_active", c_act, 0);
        check("rst_addr", c_addr, 0);
        check("rst_pclk", c_pclk, 0);
        check("rst_frame", c_ff, 0);
        check("rst_small_h", vid_b.hcount, 15);
        check("rst_small_v", vid_b.vcount, 11);

        @(negedge clk); n_rst = 1'b1;
        @(negedge clk); en_a = 1'b1;

        // First strobe after six enabled edges presents (0,0)
        step(20, 6);
        check("first_gap", gap, 6);
        check("first_h", c_h, 0);
        check("first_v", c_v, 0);
        check("first_active", c_act, 1);
        check("first_addr", c_addr, 0);
        step(20, 6);
        check("second_gap", gap, 6);
        check("second_h", c_h, 1);
        check("second_addr", c_addr, 1);

        for (int i = 2; i <= 639; i++) step(20, 6);
        check("last_vis_h", c_h, 639);
        check("last_vis_addr", c_addr, 639);
        check("last_vis_active", c_act, 1);
        step(20, 6);
        check("blank_h", c_h, 640);
        check("blank_active", c_act, 0);
        check("blank_addr_hold", c_addr, 639);
        for (int i = 641; i <= 655; i++) step(20, 6);
        check("hs_pre_h", c_h, 655);
        check("hs_pre", c_hs, 1);
        step(20, 6);
        check("hs_fall", c_hs, 0);
        for (int i = 657; i <= 751; i++) step(20, 6);
        check("hs_last_h", c_h, 751);
        check("hs_last", c_hs, 0);
        step(20, 6);
        check("hs_rise", c_hs, 1);
        for (int i = 753; i <= 799; i++) step(20, 6);
        check("line_end_h", c_h, 799);
        check("line_end_v", c_v, 0);
        step(20, 6);
        check("line1_h", c_h, 0);
        check("line1_v", c_v, 1);
        check("line1_addr", c_addr, 640);
        check("line1_active", c_act, 1);
        check("period_all_6", bad_gap, 0);

        // Pause with the divider at 3: outputs hold, no strobe
        repeat (3) @(negedge clk);
        en_a = 1'b0;
        hold_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (c_pclk !== 1'b0 || c_h !== 10'd0 || c_v !== 10'd1 || c_addr !== 20'd640) hold_bad++;
        end
        check("pause_hold", hold_bad, 0);
        en_a = 1'b1;
        step(20, 3);
        check("resume_gap", gap, 3);
        check("resume_h", c_h, 1);
        check("resume_v", c_v, 1);
        check("resume_addr", c_addr, 641);

        // Sync reset with enable high
        for (int i = 2; i <= 300; i++) step(20, 6);
        check("pre_srst_h", c_h, 300);
        s_rst = 1'b1;
        @(negedge clk);
        check("srst_h", c_h, 799);
        check("srst_v", c_v, 524);
        check("srst_pclk", c_pclk, 0);
        check("srst_active", c_act, 0);
        check("srst_addr", c_addr, 0);
        check("srst_hsync", c_hs, 1);
        s_rst = 1'b0;
        step(20, 6);
        check("post_srst_gap", gap, 6);
        check("post_srst_h", c_h, 0);
        check("post_srst_v", c_v, 0);

        // Whole frame on the small raster: 16x12 pixels, 2 clocks each
        en_a = 1'b0;
        use_b = 1'b1;
        en_b = 1'b1;
        step(10, 2);
        check("small_first_gap", gap, 2);
        check("small_first_h", c_h, 0);
        check("small_first_addr", c_addr, 0);
        ff_cycles = 0; bad_gap = 0;
        vs_bad = 0; hs_bad = 0; act_bad = 0; addr_bad = 0; vs_low = 0; frame_seen = 0; clk_cnt = 0;
        for (int i = 1; i < 193; i++) begin
            step(10, 2);
            clk_cnt += gap;
            exp_vs  = !((c_v >= 10'd8) && (c_v <= 10'd9));
            exp_hs  = !((c_h >= 10'd10) && (c_h <= 10'd12));
            exp_act = (c_h < 10'd8) && (c_v < 10'd6);
            if (c_vs !== exp_vs) vs_bad++;
            if (c_hs !== exp_hs) hs_bad++;
            if (c_act !== exp_act) act_bad++;
            if (exp_act && (c_addr !== 20'(c_v * 10'd8 + c_h))) addr_bad++;
            if (c_vs === 1'b0) vs_low++;
            if (c_ff === 1'b1) begin
                frame_seen++;
                check("frame_h", c_h, 7);
                check("frame_v", c_v, 5);
                check("frame_addr", c_addr, 47);
            end
        end
        check("small_vsync", vs_bad, 0);
        check("small_hsync", hs_bad, 0);
        check("small_active", act_bad, 0);
        check("small_addr", addr_bad, 0);
        check("small_vs_low", vs_low, 32);
        check("small_frame_seen", frame_seen, 1);
        check("small_ff_cycles", ff_cycles, 1);
        check("small_period", bad_gap, 0);
        check("frame_clks", clk_cnt, 384);
        check("wrap_h", c_h, 0);
        check("wrap_v", c_v, 0);
        check("wrap_addr", c_addr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
